// File: rtl/fc_argmax.sv
// fc_argmax: streaming signed argmax over M-element vectors with a one-entry result slot.
module fc_argmax #(
    parameter int M = 6,
    parameter int T = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 input_valid,
    output logic                 input_ready,
    input  logic [T-1:0]         input_data,
    output logic                 output_valid,
    input  logic                 output_ready,
    output logic [$clog2(M)-1:0] output_index,
    output logic [T-1:0]         output_data
);
    localparam int IW = $clog2(M);

    typedef enum logic {EMPTY, FULL} slot_t;

    slot_t                state, next_state;
    logic [IW-1:0]        cnt, run_idx, next_idx;
    logic signed [T-1:0]  run_max, next_max;
    logic                 fire, last, take;

    assign last = cnt == IW'(M - 1);
    // Only the last beat can be refused; it would otherwise overwrite an unread result.
    assign input_ready = reset && !(output_valid && !output_ready && last);
    assign fire = input_valid && input_ready;
    assign take = (cnt == '0) || ($signed(input_data) > run_max);
    assign next_max = take ? $signed(input_data) : run_max;
    assign next_idx = take ? cnt : run_idx;
    assign output_valid = state == FULL;

    always_comb begin
        next_state = state;
        next_state = (fire && last) ? FULL : (output_valid && output_ready) ? EMPTY : state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= EMPTY;
            cnt          <= '0;
            run_max      <= '0;
            run_idx      <= '0;
            output_index <= '0;
            output_data  <= '0;
        end else begin
            state <= next_state;
            if (fire) begin
                cnt     <= last ? '0 : cnt + 1'b1;
                run_max <= next_max;
                run_idx <= next_idx;
                if (last) begin
                    output_data  <= next_max;
                    output_index <= next_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_fc_argmax.sv
// tb_fc_argmax: directed and randomized checks of fc_argmax against a queue-based argmax model.
module tb_fc_argmax;
    localparam int M = 6;
    localparam int T = 16;

    logic                 clk;
    logic                 reset;
    logic                 input_valid;
    logic                 input_ready;
    logic [T-1:0]         input_data;
    logic                 output_valid;
    logic                 output_ready;
    logic [2:0]           output_index;
    logic [T-1:0]         output_data;

    int checks = 0;
    int failures = 0;

    fc_argmax #(.M(M), .T(T)) dut (
        .clk(clk),
        .reset(reset),
        .input_valid(input_valid),
        .input_ready(input_ready),
        .input_data(input_data),
        .output_valid(output_valid),
        .output_ready(output_ready),
        .output_index(output_index),
        .output_data(output_data)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic void ref_argmax(input logic signed [T-1:0] v[$], output logic [2:0] idx,
                                       output logic signed [T-1:0] mx);
        int bi = 0;
        for (int i = 1; i < v.size(); i++)
            if (v[i] > v[bi]) bi = i;
        idx = 3'(bi);
        mx = v[bi];
    endfunction

    function automatic logic signed [T-1:0] rand_elem();
        int sel = $urandom_range(0, 4);
        if (sel == 0) return 16'sh8000;
        if (sel == 1) return 16'sh7fff;
        if (sel == 2) return 16'($signed($urandom_range(0, 8)) - 4);
        return 16'($urandom);
    endfunction

    task automatic push(input logic signed [T-1:0] d);
        int n = 0;
        @(negedge clk);
        input_valid = 1;
        input_data = d;
        while (!input_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!input_ready) begin
            failures++;
            $display("FAIL push_timeout ready=%0b required 1", input_ready);
        end
        @(posedge clk);
        #1 input_valid = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        input_valid = 1;
        input_data = 16'h1234;
        output_ready = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({output_valid, output_index, output_data, input_ready} !== '0) begin
            failures++;
            $display("FAIL reset_outputs v=%0b i=%0d d=%0h r=%0b required all 0",
                     output_valid, output_index, output_data, input_ready);
        end
        input_valid = 0;
        reset = 1;
        output_ready = 1;
        @(negedge clk);
        checks++;
        if (input_ready !== 1'b1 || output_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_reset ready=%0b valid=%0b required 1 0", input_ready, output_valid);
        end
    endtask

    task automatic test_vectors();
        logic signed [T-1:0] tab[4][M] = '{
            '{16'sd3, -16'sd7, 16'sd120, 16'sd5, 16'sd120, 16'sd0},
            '{-16'sd5, -16'sd3, -16'sd32768, -16'sd3, -16'sd10, -16'sd9},
            '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd32767},
            '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0}};
        logic signed [T-1:0] v[$];
        logic [2:0] ei;
        logic signed [T-1:0] ed;
        output_ready = 1;
        for (int k = 0; k < 4; k++) begin
            v = {};
            for (int i = 0; i < M; i++) begin
                v.push_back(tab[k][i]);
                push(tab[k][i]);
            end
            ref_argmax(v, ei, ed);
            @(negedge clk);
            checks++;
            if (output_valid !== 1'b1 || output_index !== ei || output_data !== ed) begin
                failures++;
                $display("FAIL vec%0d v=%0b idx=%0d data=%0d required 1 %0d %0d", k,
                         output_valid, output_index, $signed(output_data), ei, ed);
            end
            @(negedge clk);
            checks++;
            if (output_valid !== 1'b0) begin
                failures++;
                $display("FAIL vec%0d_drop valid=%0b required 0", k, output_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic signed [T-1:0] a[$], b[$];
        logic [2:0] ai, bi;
        logic signed [T-1:0] ad, bd;
        for (int i = 0; i < M; i++) begin
            a.push_back(rand_elem());
            b.push_back(rand_elem());
        end
        ref_argmax(a, ai, ad);
        ref_argmax(b, bi, bd);
        output_ready = 0;
        for (int i = 0; i < M; i++) push(a[i]);
        for (int i = 0; i < M - 1; i++) begin
            @(negedge clk);
            input_valid = 1;
            input_data = b[i];
            checks++;
            if (input_ready !== 1'b1) begin
                failures++;
                $display("FAIL bp_beat%0d ready=%0b required 1", i, input_ready);
            end
            @(posedge clk);
            #1 input_valid = 0;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            input_valid = 1;
            input_data = b[M-1];
            checks++;
            if (input_ready !== 1'b0 || output_valid !== 1'b1 || output_index !== ai || output_data !== ad) begin
                failures++;
                $display("FAIL bp_hold%0d r=%0b v=%0b idx=%0d data=%0d required 0 1 %0d %0d", c,
                         input_ready, output_valid, output_index, $signed(output_data), ai, ad);
            end
        end
        output_ready = 1;
        #1;
        checks++;
        if (input_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release ready=%0b required 1", input_ready);
        end
        @(posedge clk);
        #1 begin
            output_ready = 0;
            input_valid = 0;
        end
        @(negedge clk);
        checks++;
        if (output_valid !== 1'b1 || output_index !== bi || output_data !== bd) begin
            failures++;
            $display("FAIL bp_second v=%0b idx=%0d data=%0d required 1 %0d %0d",
                     output_valid, output_index, $signed(output_data), bi, bd);
        end
        output_ready = 1;
        @(negedge clk);
        checks++;
        if (output_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drop valid=%0b required 0", output_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [T-1:0] v[3][$];
        logic [2:0] ei;
        logic signed [T-1:0] ed;
        output_ready = 1;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < M; i++) v[k].push_back(rand_elem());
        for (int i = 0; i <= 3 * M; i++) begin
            @(negedge clk);
            input_valid = i < 3 * M;
            if (i < 3 * M) input_data = v[i/M][i%M];
            checks++;
            if (i < 3 * M && input_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready%0d ready=%0b required 1", i, input_ready);
            end
            checks++;
            if (output_valid !== (i > 0 && i % M == 0)) begin
                failures++;
                $display("FAIL b2b_valid%0d valid=%0b required %0b", i, output_valid, i > 0 && i % M == 0);
            end
            if (i > 0 && i % M == 0) begin
                ref_argmax(v[i/M-1], ei, ed);
                checks++;
                if (output_index !== ei || output_data !== ed) begin
                    failures++;
                    $display("FAIL b2b_res%0d idx=%0d data=%0d required %0d %0d", i / M,
                             output_index, $signed(output_data), ei, ed);
                end
            end
            @(posedge clk);
        end
        #1 input_valid = 0;
    endtask

    task automatic test_reset_mid();
        output_ready = 0;
        for (int i = 0; i < M; i++) push(16'(i * 3));
        push(16'sd100);
        push(16'sd200);
        push(16'sd300);
        @(posedge clk);
        #3 reset = 0;
        #1;
        checks++;
        if ({output_valid, output_index, output_data, input_ready} !== '0) begin
            failures++;
            $display("FAIL mid_reset v=%0b i=%0d d=%0h r=%0b required all 0",
                     output_valid, output_index, output_data, input_ready);
        end
        @(negedge clk);
        reset = 1;
        output_ready = 1;
        for (int i = 0; i < M; i++) push(16'(9 - i));
        @(negedge clk);
        checks++;
        if (output_valid !== 1'b1 || output_index !== 3'd0 || output_data !== 16'd9) begin
            failures++;
            $display("FAIL mid_result v=%0b idx=%0d data=%0d required 1 0 9",
                     output_valid, output_index, $signed(output_data));
        end
        @(negedge clk);
        checks++;
        if (output_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_single valid=%0b required 0", output_valid);
        end
    endtask

    task automatic test_idle_gaps();
        logic signed [T-1:0] v[M] = '{16'sd0, 16'sd0, 16'sd50, 16'sd0, 16'sd0, 16'sd49};
        output_ready = 1;
        for (int i = 0; i < M; i++) begin
            if (i > 0)
                repeat (2) begin
                    @(negedge clk);
                    checks++;
                    if (output_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL gap_spurious%0d valid=%0b required 0", i, output_valid);
                    end
                end
            push(v[i]);
        end
        @(negedge clk);
        checks++;
        if (output_valid !== 1'b1 || output_index !== 3'd2 || output_data !== 16'd50) begin
            failures++;
            $display("FAIL gap_result v=%0b idx=%0d data=%0d required 1 2 50",
                     output_valid, output_index, $signed(output_data));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic signed [T-1:0] q[$];
        logic exp_v = 0;
        logic [2:0] ei = 0;
        logic signed [T-1:0] ed = 0;
        logic exp_r;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if (output_valid !== exp_v || (exp_v && (output_index !== ei || output_data !== ed))) begin
                failures++;
                $display("FAIL rnd_out%0d v=%0b idx=%0d data=%0d required %0b %0d %0d", c,
                         output_valid, output_index, $signed(output_data), exp_v, ei, ed);
            end
            output_ready = $urandom_range(0, 2) != 0;
            input_valid = $urandom_range(0, 3) != 0;
            input_data = rand_elem();
            #1;
            exp_r = !(exp_v && !output_ready && q.size() == M - 1);
            checks++;
            if (input_ready !== exp_r) begin
                failures++;
                $display("FAIL rnd_ready%0d ready=%0b required %0b", c, input_ready, exp_r);
            end
            if (exp_v && output_ready) exp_v = 0;
            if (input_valid && exp_r) begin
                q.push_back(input_data);
                if (q.size() == M) begin
                    ref_argmax(q, ei, ed);
                    exp_v = 1;
                    q = {};
                end
            end
        end
        @(negedge clk);
        input_valid = 0;
    endtask

    initial begin
        reset = 0;
        input_valid = 0;
        input_data = 0;
        output_ready = 0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_idle_gaps();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fc_argmax.md
# fc_argmax

Classification stage placed directly downstream of an fc layer. It consumes the layer's serial output stream of M signed T-bit activations per vector and reports the index and value of the largest element. One result is produced per M accepted beats. A one-entry result slot lets collection of the next vector overlap with a stalled result consumer.

## Interface
- M, 6: elements per vector (fc output rows); M >= 2
- T, 16: element width, signed two's complement
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- input_valid  input  1  upstream has a beat on input_data
- input_ready  output  1  block accepts the beat this cycle
- input_data  input  T  signed activation, element order 0..M-1
- output_valid  output  1  result slot full
- output_ready  input  1  downstream takes the result this cycle
- output_index  output  $clog2(M)  argmax index, 0..M-1
- output_data  output  T  signed maximum value

## Operation
- Beat accepted when input_valid && input_ready (fire).
- Element counter cnt, 0..M-1; increments on each fire; wraps to 0 after the beat with cnt == M-1.
- Running registers run_max (T bits, signed) and run_idx.
  - Fire with cnt == 0: run_max <= input_data, run_idx <= 0 (unconditional load; -2^(T-1) handled correctly).
  - Fire with cnt > 0: if input_data > run_max (signed, strict), run_max <= input_data, run_idx <= cnt; otherwise hold.
  - Ties: lowest index wins.
- Last beat (cnt == M-1) fire: the final comparison (including this beat) is written straight into the result slot: output_data, output_index, output_valid <= 1. The running registers become don't-care.
- Result slot states: EMPTY (output_valid = 0) and FULL (output_valid = 1).
  - EMPTY -> FULL on last-beat fire.
  - FULL -> EMPTY on output_valid && output_ready with no simultaneous last-beat fire.
  - FULL stays FULL (new result overwrites) when output_ready && last-beat fire occur in the same cycle.
- input_ready = 0 when output_valid && !output_ready && cnt == M-1; otherwise 1.
  - Beats 0..M-2 of the next vector are always accepted.
  - There is a combinational path from output_ready to input_ready. input_ready does not depend on input_valid.
- No arithmetic beyond signed compare; no saturation or width growth.

## Timing
- While reset is low: cnt = 0, output_valid = 0, output_index = 0, output_data = 0, input_ready = 0, run_max = 0, run_idx = 0.
- First clock after reset deasserts: input_ready = 1.
- Reset mid-vector discards the partial vector and any pending result.
- Latency: output_valid rises on the clock edge that accepts the last beat, so it is visible in the following cycle.
- Result is stable while output_valid && !output_ready.
- Throughput: one beat per cycle. Back-to-back vectors run with zero bubbles when output_ready is high whenever output_valid is high.
- Stall: with the slot FULL and output_ready low, the last beat of the next vector waits. It is accepted in the first cycle output_ready goes high. The new result appears the following cycle and output_valid stays high.
- input_valid low: cnt and the running registers hold.

## Test plan
- Vector [3, -7, 120, 5, 120, 0], output_ready = 1 -> one cycle after beat 5, output_valid = 1, output_index = 2, output_data = 120; output_valid drops the next cycle.
- Vector [-5, -3, -32768, -3, -10, -9] -> output_index = 1, output_data = -3. Vector [1, 2, 3, 4, 5, 32767] -> output_index = 5, output_data = 32767. All-zero vector -> output_index = 0, output_data = 0.
- Back-pressure: two vectors streamed continuously, output_ready = 0 -> beats 0..4 of vector 2 accepted, input_ready = 0 on beat 5, first result held. Raising output_ready for one cycle -> beat 5 accepted that cycle; the next cycle shows the vector-2 result with output_valid still 1.
- Three back-to-back vectors, output_ready tied high -> 18 consecutive fires and three results on cycles 6, 12 and 18 after the first fire; no bubbles.
- Reset pulsed low after 3 beats of [100, 200, 300, ...], then vector [9, 8, 7, 6, 5, 4] -> single result output_index = 0, output_data = 9. All outputs read 0 during reset.
- Idle gaps: vector [0, 0, 50, 0, 0, 49] with input_valid low for 2 cycles between beats -> output_index = 2, output_data = 50; no spurious output_valid before beat 5.
